instr_encoder: RTL and testbench
================================

# instr_encoder

- Field-level RV32I instruction encoder and instruction-memory writer.
- Covers the same subset the core's controller decodes: ADD, SUB, AND, OR, ADDI, LW, SW, BEQ.
- Accepts one instruction request per handshake, packs it into a 32-bit instruction word, and writes it to the next sequential instruction-memory word address.
- Sits between the test/boot loader and instruction memory; it produces the words the controller later decodes.

## Interface

Parameters:
- ADDR_W, 8: instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clr  in  1  synchronous restart. Clears pointer, full and err.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  opcode select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ.
- req_rd, req_rs1, req_rs2  in  5 each  register fields.
- req_imm  in  13  immediate, two's complement:
  - I/S-type use req_imm[11:0].
  - BEQ uses the full 13-bit byte offset.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/clr.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag.

## Operation

States: IDLE, WRITE (plus PAD when configured).

- IDLE:
  - req_ready = !full.
  - On req_valid && req_ready, register the encoded word and ptr into imem_wdata/imem_addr, then go to WRITE.
- WRITE:
  - imem_we = 1 for exactly one cycle; req_ready = 0.
  - Next: ptr/count += 1, return to IDLE.
  - full rises when count reaches DEPTH.

Encoding (field order MSB to LSB):
- R-type: funct7, rs2, rs1, funct3, rd, 0110011.
  - funct7 = 0100000 for SUB, else 0000000.
  - funct3: ADD/SUB 000, AND 111, OR 110.
- ADDI: imm[11:0], rs1, 000, rd, 0010011.
- LW: imm[11:0], rs1, 010, rd, 0000011.
- SW: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
- BEQ: imm[12], imm[10:5], rs2, rs1, 000, imm[4:1], imm[11], 1100011.
- Unused fields for an op are ignored, e.g. rs2 for ADDI and rd for SW/BEQ.

Boundaries:
- BEQ with req_imm[0] = 1: the word is still written with bit 0 dropped, and err is set.
- req_valid while full: nothing is written and err is set. The request is not consumed because req_ready = 0.
- clr has priority over everything:
  - Next state is IDLE; ptr, count, full and err go to 0.
  - A write strobe already high in the clr cycle still completes, but the pointer does not advance.
  - A request presented in the same cycle as clr is not accepted.
- err clears only on rst_n or clr.

## Timing

- Reset values: req_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, count = 0, full = 0, err = 0, state IDLE.
- All outputs are registered except req_ready, which is decoded from state and full.
- Latency: request accepted at edge N gives imem_we = 1 during cycle N+1 with valid addr/wdata.
- Throughput: one instruction per 2 cycles.
- count and full update at the edge that ends the WRITE cycle.
- imem_addr wraps naturally, but full prevents any write beyond DEPTH-1.

## Configuration

- INSTR_ENC_PAD_EN defined:
  - Adds input pad_req (1 bit) and state PAD.
  - pad_req sampled high in IDLE with !full enters PAD.
  - PAD writes NOP 0x00000013 (addi x0,x0,0) to ptr every cycle, with imem_we = 1 and ptr += 1 per cycle, until full. It then returns to IDLE.
  - req_ready = 0 throughout PAD; clr aborts PAD.
  - pad_req while full is ignored; it does not set err.
- INSTR_ENC_PAD_EN undefined: no pad_req port and no PAD state.

## Test plan

- ADD x3,x1,x2 (op 0, rd 3, rs1 1, rs2 2) -> imem_we for 1 cycle, addr 0, wdata 0x002081B3. SUB with the same fields -> 0x402081B3 at addr 1.
- ADDI x5,x0,-1 (imm 0x1FFF) -> 0xFFF00293. LW x6,8(x2) -> 0x00812303. SW x6,12(x2) -> 0x00612623.
- BEQ x1,x2,-8 (imm 0x1FF8) -> 0xFE208CE3, err stays 0. BEQ with imm 0x0005 -> word written, err = 1.
- ADDR_W = 2, 4 back-to-back requests with req_valid held -> addrs 0..3 written 2 cycles apart, then full = 1, count = 4, req_ready = 0. 5th request -> no imem_we, err = 1. clr -> count 0, full 0, err 0, next request writes addr 0.
- rst_n asserted low mid-WRITE -> imem_we drops immediately and all outputs return to reset values without waiting for clk.
- With INSTR_ENC_PAD_EN, ADDR_W = 3, 2 instructions written, then pad_req -> 6 consecutive cycles of 0x00000013 at addrs 2..7, then full = 1.

Source files
------------

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-memory bundle for instr_encoder
// master drives requests and observes writes; slave is the encoder.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
) ();
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [12:0]       req_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   modport master (
      output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      input  req_ready, imem_we, imem_addr, imem_wdata, count, full, err
   );

   modport slave (
      input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
      output req_ready, imem_we, imem_addr, imem_wdata, count, full, err
   );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I subset encoder writing sequential instruction-memory words
// Optional NOP fill-to-end mode is enabled by defining INSTR_ENC_PAD_EN.
module instr_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
`ifdef INSTR_ENC_PAD_EN
   input  logic pad_req,
`endif
   instr_encoder_if.slave bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef INSTR_ENC_PAD_EN
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PAD} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WRITE} state_t;
`endif

   state_t            r_state;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_err;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;

   logic              w_ready;
   logic              w_accept;
   logic [ADDR_W-1:0] w_ptr;
   logic [ADDR_W:0]   w_count_inc;
   logic [31:0]       w_enc;
   logic [12:0]       w_imm;

   assign w_ready     = (r_state == S_IDLE) && !r_full;
   assign w_accept    = bus.req_valid && w_ready;
   // The write pointer is the low bits of count; count's MSB alone marks DEPTH.
   assign w_ptr       = r_count[ADDR_W-1:0];
   assign w_count_inc = r_count + 1'b1;
   assign w_imm       = bus.req_imm;

   always_comb begin
      w_enc = '0;
      case (bus.req_op)
         3'd0: w_enc = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b000, bus.req_rd, 7'b0110011};
         3'd1: w_enc = {7'b0100000, bus.req_rs2, bus.req_rs1, 3'b000, bus.req_rd, 7'b0110011};
         3'd2: w_enc = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b111, bus.req_rd, 7'b0110011};
         3'd3: w_enc = {7'b0000000, bus.req_rs2, bus.req_rs1, 3'b110, bus.req_rd, 7'b0110011};
         3'd4: w_enc = {w_imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, 7'b0010011};
         3'd5: w_enc = {w_imm[11:0], bus.req_rs1, 3'b010, bus.req_rd, 7'b0000011};
         3'd6: w_enc = {w_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010, w_imm[4:0], 7'b0100011};
         default: w_enc = {w_imm[12], w_imm[10:5], bus.req_rs2, bus.req_rs1, 3'b000,
                           w_imm[4:1], w_imm[11], 7'b1100011};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (clr) begin
         // A strobe visible this cycle finishes on its own; nothing is counted for it.
         r_state <= S_IDLE;
         r_count <= '0;
         r_full  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_we <= 1'b0;
               if (w_accept) begin
                  r_addr  <= w_ptr;
                  r_wdata <= w_enc;
                  r_we    <= 1'b1;
                  r_state <= S_WRITE;
                  if (bus.req_op == 3'd7 && w_imm[0])
                     r_err <= 1'b1;
               end else if (bus.req_valid && r_full) begin
                  r_err <= 1'b1;
               end
`ifdef INSTR_ENC_PAD_EN
               else if (pad_req && !r_full) begin
                  r_addr  <= w_ptr;
                  r_wdata <= NOP;
                  r_we    <= 1'b1;
                  r_state <= S_PAD;
               end
`endif
            end
            S_WRITE: begin
               r_we    <= 1'b0;
               r_count <= w_count_inc;
               r_full  <= w_count_inc[ADDR_W];
               r_state <= S_IDLE;
            end
`ifdef INSTR_ENC_PAD_EN
            S_PAD: begin
               r_count <= w_count_inc;
               if (w_count_inc[ADDR_W]) begin
                  r_full  <= 1'b1;
                  r_we    <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_addr <= w_count_inc[ADDR_W-1:0];
                  r_we   <= 1'b1;
               end
            end
`endif
            default: begin
               r_we    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.count      = r_count;
   assign bus.full       = r_full;
   assign bus.err        = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
// Three instances: ADDR_W=8 for encoding, ADDR_W=2 for fill/clr, ADDR_W=3 for NOP padding.
module tb_instr_encoder;
   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(8)) if_a ();
   instr_encoder_if #(.ADDR_W(2)) if_b ();

`ifdef INSTR_ENC_PAD_EN
   logic pad_a, pad_b, pad_c;
   instr_encoder_if #(.ADDR_W(3)) if_c ();
   instr_encoder #(.ADDR_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .pad_req(pad_a), .bus(if_a));
   instr_encoder #(.ADDR_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .pad_req(pad_b), .bus(if_b));
   instr_encoder #(.ADDR_W(3)) u_dut_c (.clk(clk), .rst_n(rst_n), .clr(clr), .pad_req(pad_c), .bus(if_c));
`else
   instr_encoder #(.ADDR_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_a));
   instr_encoder #(.ADDR_W(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if_b));
`endif

   typedef struct packed {
      logic [2:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      logic [31:0] word;
   } vec_t;

   // Hand-encoded; ignored fields (rs2 for ADDI, rd for SW/BEQ) carry junk on purpose.
   vec_t vecs [8] = '{
      '{3'd0, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h002081B3},
      '{3'd1, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h402081B3},
      '{3'd4, 5'd5, 5'd0, 5'd7, 13'h1FFF, 32'hFFF00293},
      '{3'd5, 5'd6, 5'd2, 5'd0, 13'h0008, 32'h00812303},
      '{3'd6, 5'd9, 5'd2, 5'd6, 13'h000C, 32'h00612623},
      '{3'd7, 5'd5, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3},
      '{3'd2, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h0020F1B3},
      '{3'd3, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h0020E1B3}
   };

   task automatic drive_a(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [12:0] imm);
      if_a.req_op = op; if_a.req_rd = rd; if_a.req_rs1 = rs1; if_a.req_rs2 = rs2; if_a.req_imm = imm;
      if_a.req_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({if_a.req_ready, if_a.imem_we, if_a.full, if_a.err} !== 4'b1000 ||
          if_a.imem_addr !== 8'd0 || if_a.imem_wdata !== 32'd0 || if_a.count !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_a: rdy/we/full/err=%b addr=%0d wdata=%h count=%0d want 1000/0/0/0",
                  {if_a.req_ready, if_a.imem_we, if_a.full, if_a.err}, if_a.imem_addr, if_a.imem_wdata, if_a.count);
      end
      n_cmp++;
      if ({if_b.req_ready, if_b.imem_we, if_b.full, if_b.err} !== 4'b1000 || if_b.count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_b: rdy/we/full/err=%b count=%0d want 1000/0",
                  {if_b.req_ready, if_b.imem_we, if_b.full, if_b.err}, if_b.count);
      end
   endtask

   task automatic test_encode();
      for (int i = 0; i < 8; i++) begin
         drive_a(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
         @(negedge clk);
         if_a.req_valid = 1'b0;
         n_cmp++;
         if (if_a.imem_we !== 1'b1 || if_a.imem_addr !== 8'(i) || if_a.imem_wdata !== vecs[i].word) begin
            n_fail++;
            $display("FAIL enc[%0d]: we=%b addr=%0d wdata=%h want we=1 addr=%0d wdata=%h",
                     i, if_a.imem_we, if_a.imem_addr, if_a.imem_wdata, i, vecs[i].word);
         end
         @(negedge clk);
         n_cmp++;
         if (if_a.imem_we !== 1'b0 || if_a.count !== 9'(i + 1) || if_a.err !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_post[%0d]: we=%b count=%0d err=%b want we=0 count=%0d err=0",
                     i, if_a.imem_we, if_a.count, if_a.err, i + 1);
         end
      end
   endtask

   task automatic test_beq_misaligned();
      drive_a(3'd7, 5'd0, 5'd1, 5'd2, 13'h0005);
      @(negedge clk);
      if_a.req_valid = 1'b0;
      n_cmp++;
      if (if_a.imem_we !== 1'b1 || if_a.imem_addr !== 8'd8 || if_a.imem_wdata !== 32'h00208263 || if_a.err !== 1'b1) begin
         n_fail++;
         $display("FAIL beq_odd: we=%b addr=%0d wdata=%h err=%b want 1/8/00208263/1",
                  if_a.imem_we, if_a.imem_addr, if_a.imem_wdata, if_a.err);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      if_b.req_op = 3'd0; if_b.req_rd = 5'd3; if_b.req_rs1 = 5'd1; if_b.req_rs2 = 5'd2; if_b.req_imm = 13'd0;
      if_b.req_valid = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (if_b.imem_we === 1'b1) begin
            n_cmp++;
            if (if_b.imem_addr !== 2'(pulses) || k != 1 + 2 * pulses || pulses >= 4) begin
               n_fail++;
               $display("FAIL b2b_pulse[%0d]: addr=%0d cycle=%0d want addr=%0d cycle=%0d (max 4 pulses)",
                        pulses, if_b.imem_addr, k, pulses, 1 + 2 * pulses);
            end
            pulses++;
         end
      end
      n_cmp++;
      if (pulses != 4) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d want 4", pulses);
      end
      n_cmp++;
      if (if_b.full !== 1'b1 || if_b.count !== 3'd4 || if_b.req_ready !== 1'b0 || if_b.err !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_full: full=%b count=%0d ready=%b err=%b want 1/4/0/1",
                  if_b.full, if_b.count, if_b.req_ready, if_b.err);
      end
   endtask

   task automatic test_clr();
      if_b.req_valid = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_cmp++;
      if (if_b.count !== 3'd0 || if_b.full !== 1'b0 || if_b.err !== 1'b0 || if_b.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_state: count=%0d full=%b err=%b ready=%b want 0/0/0/1",
                  if_b.count, if_b.full, if_b.err, if_b.req_ready);
      end
      if_b.req_valid = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_cmp++;
      if (if_b.imem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_blocks_req: we=%b want 0", if_b.imem_we);
      end
      @(negedge clk);
      if_b.req_valid = 1'b0;
      n_cmp++;
      if (if_b.imem_we !== 1'b1 || if_b.imem_addr !== 2'd0) begin
         n_fail++;
         $display("FAIL clr_first_write: we=%b addr=%0d want 1/0", if_b.imem_we, if_b.imem_addr);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      n_cmp++;
      if (if_b.count !== 3'd0 || if_b.imem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_mid_write: count=%0d we=%b want 0/0", if_b.count, if_b.imem_we);
      end
      if_b.req_valid = 1'b1;
      @(negedge clk);
      if_b.req_valid = 1'b0;
      n_cmp++;
      if (if_b.imem_we !== 1'b1 || if_b.imem_addr !== 2'd0) begin
         n_fail++;
         $display("FAIL clr_rewrite: we=%b addr=%0d want 1/0", if_b.imem_we, if_b.imem_addr);
      end
      @(negedge clk);
      n_cmp++;
      if (if_b.count !== 3'd1) begin
         n_fail++;
         $display("FAIL clr_count: count=%0d want 1", if_b.count);
      end
   endtask

   task automatic test_async_reset();
      drive_a(3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
      @(negedge clk);
      if_a.req_valid = 1'b0;
      n_cmp++;
      if (if_a.imem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_pre: we=%b want 1", if_a.imem_we);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({if_a.req_ready, if_a.imem_we, if_a.full, if_a.err} !== 4'b1000 ||
          if_a.imem_addr !== 8'd0 || if_a.imem_wdata !== 32'd0 || if_a.count !== 9'd0) begin
         n_fail++;
         $display("FAIL arst_a: rdy/we/full/err=%b addr=%0d wdata=%h count=%0d want 1000/0/0/0",
                  {if_a.req_ready, if_a.imem_we, if_a.full, if_a.err}, if_a.imem_addr, if_a.imem_wdata, if_a.count);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

`ifdef INSTR_ENC_PAD_EN
   task automatic test_pad();
      int pulses = 0;
      int first = 0;
      if_c.req_op = 3'd0; if_c.req_rd = 5'd3; if_c.req_rs1 = 5'd1; if_c.req_rs2 = 5'd2; if_c.req_imm = 13'd0;
      for (int i = 0; i < 2; i++) begin
         if_c.req_valid = 1'b1;
         @(negedge clk);
         if_c.req_valid = 1'b0;
         @(negedge clk);
      end
      pad_c = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         pad_c = 1'b0;
         if (if_c.imem_we === 1'b1) begin
            if (pulses == 0) first = k;
            n_cmp++;
            if (if_c.imem_addr !== 3'(2 + pulses) || if_c.imem_wdata !== 32'h00000013 || k != first + pulses) begin
               n_fail++;
               $display("FAIL pad[%0d]: addr=%0d wdata=%h cycle=%0d want addr=%0d wdata=00000013 cycle=%0d",
                        pulses, if_c.imem_addr, if_c.imem_wdata, k, 2 + pulses, first + pulses);
            end
            pulses++;
         end
      end
      n_cmp++;
      if (pulses != 6 || first != 1 || if_c.full !== 1'b1 || if_c.count !== 4'd8 || if_c.err !== 1'b0) begin
         n_fail++;
         $display("FAIL pad_end: pulses=%0d first=%0d full=%b count=%0d err=%b want 6/1/1/8/0",
                  pulses, first, if_c.full, if_c.count, if_c.err);
      end
      pad_c = 1'b1;
      repeat (2) @(negedge clk);
      pad_c = 1'b0;
      n_cmp++;
      if (if_c.imem_we !== 1'b0 || if_c.err !== 1'b0) begin
         n_fail++;
         $display("FAIL pad_full: we=%b err=%b want 0/0", if_c.imem_we, if_c.err);
      end
   endtask
`endif

   initial begin
      clr = 1'b0;
      rst_n = 1'b0;
      if_a.req_valid = 1'b0; if_a.req_op = '0; if_a.req_rd = '0; if_a.req_rs1 = '0; if_a.req_rs2 = '0; if_a.req_imm = '0;
      if_b.req_valid = 1'b0; if_b.req_op = '0; if_b.req_rd = '0; if_b.req_rs1 = '0; if_b.req_rs2 = '0; if_b.req_imm = '0;
`ifdef INSTR_ENC_PAD_EN
      pad_a = 1'b0; pad_b = 1'b0; pad_c = 1'b0;
      if_c.req_valid = 1'b0; if_c.req_op = '0; if_c.req_rd = '0; if_c.req_rs1 = '0; if_c.req_rs2 = '0; if_c.req_imm = '0;
`endif
      test_reset();
      test_encode();
      test_beq_misaligned();
      test_back_to_back();
      test_clr();
      test_async_reset();
`ifdef INSTR_ENC_PAD_EN
      test_pad();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
